// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcode/funct
// constants and datapath select codes.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DCD   = 3'd1,
    S_EXE   = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_DM  = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  function automatic logic is_supported(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: ok = (fn == FN_ADDU) || (fn == FN_SUBU) || (fn == FN_SLT) || (fn == FN_JR);
      OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_LUI,
      OP_J, OP_JAL, OP_ADDI, OP_ADDIU: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// Memory wait logic: either a fixed-latency counter or the external ready strobe,
// reduced to a single mem_done flag for the controller.
module mc_mem_wait
  import mc_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter bit USE_RDY = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic mem_rdy_i,
  output logic mem_done_o
);

  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

  logic [3:0] cnt_q, cnt_d;

  assign mem_done_o = USE_RDY ? mem_rdy_i : (cnt_q == LAST);

  // Counter only runs while an access is in flight and restarts on every completion.
  always_comb begin
    cnt_d = 4'd0;
    if (active_i && !mem_done_o) cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM (FETCH/DCD/EXE/MEM/WB).
// Optional performance counters are enabled with the MC_PERF_CNT_EN macro.
module mc_controller
  import mc_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter bit USE_RDY = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_rdy,
  output logic       mem_req,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] RegDst,
  output logic       ALUSrc,
  output logic [1:0] MemtoReg,
  output logic [1:0] Extop,
  output logic [2:0] ALUctr,
  output logic       npc_sel,
  output logic       j_sel,
  output logic       jr_sel,
  output logic       jal_sel,
  output logic       addi_sel,
  output logic       ovf_err,
  output logic       ill_op,
  output logic [2:0] state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] instr_cnt
`endif
);

  state_e state_q, state_d;
  logic   mem_done;
  logic   mem_active;

  assign mem_active = (state_q == S_FETCH) || (state_q == S_MEM);
  assign state      = rst ? 3'd0 : state_q;

  mc_mem_wait #(.MEM_LAT(MEM_LAT), .USE_RDY(USE_RDY)) u_wait (
    .clk       (clk),
    .rst       (rst),
    .active_i  (mem_active),
    .mem_rdy_i (mem_rdy),
    .mem_done_o(mem_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // All outputs stay low during reset so an aborted instruction never writes.
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    RegDst   = DST_RT;
    ALUSrc   = 1'b0;
    MemtoReg = MTR_ALU;
    Extop    = EXT_ZERO;
    ALUctr   = ALU_ADD;
    npc_sel  = 1'b0;
    j_sel    = 1'b0;
    jr_sel   = 1'b0;
    jal_sel  = 1'b0;
    addi_sel = 1'b0;
    ovf_err  = 1'b0;
    ill_op   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_done) begin
            IRWr    = 1'b1;
            PCWr    = 1'b1;
            state_d = S_DCD;
          end
        end
        S_DCD: begin
          state_d = S_FETCH;
          if (opcode == OP_J) begin
            PCWr  = 1'b1;
            j_sel = 1'b1;
          end else if (opcode == OP_JAL) begin
            PCWr     = 1'b1;
            j_sel    = 1'b1;
            jal_sel  = 1'b1;
            RegWrite = 1'b1;
            RegDst   = DST_RA;
            MemtoReg = MTR_PC4;
          end else if (opcode == OP_RTYPE && funct == FN_JR) begin
            PCWr   = 1'b1;
            jr_sel = 1'b1;
          end else if (!is_supported(opcode, funct)) begin
            ill_op = 1'b1;
          end else begin
            state_d = S_EXE;
          end
        end
        S_EXE: begin
          state_d = S_WB;
          case (opcode)
            OP_RTYPE: begin
              if (funct == FN_SUBU)     ALUctr = ALU_SUB;
              else if (funct == FN_SLT) ALUctr = ALU_SLT;
              else                      ALUctr = ALU_ADD;
            end
            OP_ORI: begin
              ALUSrc = 1'b1;
              ALUctr = ALU_OR;
            end
            OP_ADDIU: begin
              ALUSrc = 1'b1;
              Extop  = EXT_SIGN;
            end
            OP_LUI: begin
              ALUSrc = 1'b1;
              Extop  = EXT_LUI;
            end
            OP_ADDI: begin
              ALUSrc   = 1'b1;
              Extop    = EXT_SIGN;
              addi_sel = 1'b1;
            end
            OP_LW, OP_SW: begin
              ALUSrc  = 1'b1;
              Extop   = EXT_SIGN;
              state_d = S_MEM;
            end
            OP_BEQ: begin
              ALUctr  = ALU_SUB;
              npc_sel = 1'b1;
              PCWr    = zero;
              state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          if (mem_done) begin
            if (opcode == OP_SW) begin
              MemWrite = 1'b1;
              state_d  = S_FETCH;
            end else begin
              state_d  = S_WB;
            end
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          state_d  = S_FETCH;
          if (opcode == OP_RTYPE) RegDst   = DST_RD;
          if (opcode == OP_LW)    MemtoReg = MTR_DM;
          if (opcode == OP_ADDI && overflow) begin
            RegWrite = 1'b0;
            ovf_err  = 1'b1;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_q, instr_q;

  assign cyc_cnt   = cyc_q;
  assign instr_cnt = instr_q;

  // An instruction retires whenever the FSM re-enters FETCH, unless decode rejected it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q   <= 32'd0;
      instr_q <= 32'd0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (state_d == S_FETCH && state_q != S_FETCH && !ill_op) instr_q <= instr_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Table-driven, scoreboarded bench for mc_controller; three instances cover
// MEM_LAT=1, MEM_LAT=3 and USE_RDY=1 while sharing the same input stimulus.
module tb_mc_controller;

  localparam logic [5:0] R = 6'b000000, ORI = 6'b001101, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, LUI = 6'b001111, J = 6'b000010, JAL = 6'b000011;
  localparam logic [5:0] ADDI = 6'b001000, ADDIU = 6'b001001, BAD = 6'b111111;
  localparam logic [5:0] ADDU = 6'b100001, SUBU = 6'b100011, SLT = 6'b101010, JR = 6'b001000;
  localparam logic [5:0] NOFN = 6'b000000;
  localparam logic [9:0] M0 = 10'b00_0_00_00_000;
  localparam logic [6:0] S0 = 7'b0000000;

  typedef struct {
    int          sel;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zero;
    logic        ovf;
    logic        rdy;
    logic [24:0] exp;
  } vec_t;

  typedef struct {
    int          sel;
    int          idx;
    logic [24:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, overflow = 1'b0, mem_rdy = 1'b0;
  logic [2:0][24:0] obs;

  vec_t vec[$];
  sb_t  sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // obs packing: {state, mem_req, PCWr, IRWr, RegWrite, MemWrite, RegDst, ALUSrc,
  //               MemtoReg, Extop, ALUctr, npc_sel, j_sel, jr_sel, jal_sel, addi_sel, ovf_err, ill_op}
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic memReq, pcWr, irWr, regWrite, memWrite, aluSrc;
    logic [1:0] regDst, memtoReg, extop;
    logic [2:0] aluCtr, stateOut;
    logic npcSel, jSel, jrSel, jalSel, addiSel, ovfErr, illOp;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycCnt, instrCnt;
`endif

    mc_controller #(.MEM_LAT(g == 1 ? 3 : 1), .USE_RDY(g == 2)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .overflow(overflow), .mem_rdy(mem_rdy), .mem_req(memReq), .PCWr(pcWr),
      .IRWr(irWr), .RegWrite(regWrite), .MemWrite(memWrite), .RegDst(regDst),
      .ALUSrc(aluSrc), .MemtoReg(memtoReg), .Extop(extop), .ALUctr(aluCtr),
      .npc_sel(npcSel), .j_sel(jSel), .jr_sel(jrSel), .jal_sel(jalSel),
      .addi_sel(addiSel), .ovf_err(ovfErr), .ill_op(illOp), .state(stateOut)
`ifdef MC_PERF_CNT_EN
      , .cyc_cnt(cycCnt), .instr_cnt(instrCnt)
`endif
    );

    assign obs[g] = {stateOut, memReq, pcWr, irWr, regWrite, memWrite, regDst, aluSrc,
                     memtoReg, extop, aluCtr, npcSel, jSel, jrSel, jalSel, addiSel, ovfErr, illOp};
  end

  // en = {mem_req, PCWr, IRWr, RegWrite, MemWrite}; mux = {RegDst, ALUSrc, MemtoReg, Extop, ALUctr}
  // sl = {npc_sel, j_sel, jr_sel, jal_sel, addi_sel, ovf_err, ill_op}
  task automatic add(input int sel, input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic ov, input logic rd, input logic [2:0] st,
                     input logic [4:0] en, input logic [9:0] mux, input logic [6:0] sl);
    vec_t v;
    v.sel = sel; v.rst = r; v.op = op; v.fn = fn; v.zero = z; v.ovf = ov; v.rdy = rd;
    v.exp = {st, en, mux, sl};
    vec.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    sb_t e;
    rst = v.rst; opcode = v.op; funct = v.fn; zero = v.zero; overflow = v.ovf; mem_rdy = v.rdy;
    e.sel = v.sel; e.idx = idx; e.exp = v.exp;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    sb_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard empty");
    end else begin
      e = sb.pop_front();
      if (obs[e.sel] !== e.exp) begin
        errors++;
        $display("[TB] FAIL vec%0d dut%0d got=%b exp=%b", e.idx, e.sel, obs[e.sel], e.exp);
      end
    end
  endtask

  initial begin
    int cyc;
    bit seen;

    // MEM_LAT=1: reset during DCD, then every instruction class.
    add(0,1,R,ADDU,0,0,0, 3'd0,5'b00000,M0,S0);
    add(0,0,R,ADDU,0,0,0, 3'd0,5'b11100,M0,S0);
    add(0,1,R,ADDU,0,0,0, 3'd0,5'b00000,M0,S0);
    add(0,1,R,ADDU,0,0,0, 3'd0,5'b00000,M0,S0);
    add(0,0,R,ADDU,0,0,0, 3'd0,5'b11100,M0,S0);
    add(0,0,R,ADDU,0,0,0, 3'd1,5'b00000,M0,S0);
    add(0,0,R,ADDU,0,0,0, 3'd2,5'b00000,M0,S0);
    add(0,0,R,ADDU,0,0,0, 3'd4,5'b00010,10'b01_0_00_00_000,S0);
    add(0,0,R,SLT,0,0,0,  3'd0,5'b11100,M0,S0);
    add(0,0,R,SLT,0,0,0,  3'd1,5'b00000,M0,S0);
    add(0,0,R,SLT,0,0,0,  3'd2,5'b00000,10'b00_0_00_00_011,S0);
    add(0,0,R,SLT,0,0,0,  3'd4,5'b00010,10'b01_0_00_00_000,S0);
    add(0,0,R,SUBU,0,0,0, 3'd0,5'b11100,M0,S0);
    add(0,0,R,SUBU,0,0,0, 3'd1,5'b00000,M0,S0);
    add(0,0,R,SUBU,0,0,0, 3'd2,5'b00000,10'b00_0_00_00_001,S0);
    add(0,0,R,SUBU,0,0,0, 3'd4,5'b00010,10'b01_0_00_00_000,S0);
    add(0,0,BEQ,NOFN,1,0,0, 3'd0,5'b11100,M0,S0);
    add(0,0,BEQ,NOFN,1,0,0, 3'd1,5'b00000,M0,S0);
    add(0,0,BEQ,NOFN,1,0,0, 3'd2,5'b01000,10'b00_0_00_00_001,7'b1000000);
    add(0,0,BEQ,NOFN,0,0,0, 3'd0,5'b11100,M0,S0);
    add(0,0,BEQ,NOFN,0,0,0, 3'd1,5'b00000,M0,S0);
    add(0,0,BEQ,NOFN,0,0,0, 3'd2,5'b00000,10'b00_0_00_00_001,7'b1000000);
    add(0,0,ADDI,NOFN,0,0,0, 3'd0,5'b11100,M0,S0);
    add(0,0,ADDI,NOFN,0,0,0, 3'd1,5'b00000,M0,S0);
    add(0,0,ADDI,NOFN,0,0,0, 3'd2,5'b00000,10'b00_1_00_01_000,7'b0000100);
    add(0,0,ADDI,NOFN,0,1,0, 3'd4,5'b00000,M0,7'b0000010);
    add(0,0,ORI,NOFN,0,1,0,  3'd0,5'b11100,M0,S0);
    add(0,0,ORI,NOFN,0,0,0,  3'd1,5'b00000,M0,S0);
    add(0,0,ORI,NOFN,0,0,0,  3'd2,5'b00000,10'b00_1_00_00_010,S0);
    add(0,0,ORI,NOFN,0,0,0,  3'd4,5'b00010,M0,S0);
    add(0,0,LUI,NOFN,0,0,0,  3'd0,5'b11100,M0,S0);
    add(0,0,LUI,NOFN,0,0,0,  3'd1,5'b00000,M0,S0);
    add(0,0,LUI,NOFN,0,0,0,  3'd2,5'b00000,10'b00_1_00_10_000,S0);
    add(0,0,LUI,NOFN,0,0,0,  3'd4,5'b00010,M0,S0);
    add(0,0,ADDIU,NOFN,0,0,0, 3'd0,5'b11100,M0,S0);
    add(0,0,ADDIU,NOFN,0,0,0, 3'd1,5'b00000,M0,S0);
    add(0,0,ADDIU,NOFN,0,0,0, 3'd2,5'b00000,10'b00_1_00_01_000,S0);
    add(0,0,ADDIU,NOFN,0,1,0, 3'd4,5'b00010,M0,S0);
    add(0,0,JAL,NOFN,0,0,0,  3'd0,5'b11100,M0,S0);
    add(0,0,JAL,NOFN,0,0,0,  3'd1,5'b01010,10'b10_0_10_00_000,7'b0101000);
    add(0,0,R,JR,0,0,0,      3'd0,5'b11100,M0,S0);
    add(0,0,R,JR,0,0,0,      3'd1,5'b01000,M0,7'b0010000);
    add(0,0,J,NOFN,0,0,0,    3'd0,5'b11100,M0,S0);
    add(0,0,J,NOFN,0,0,0,    3'd1,5'b01000,M0,7'b0100000);
    add(0,0,BAD,NOFN,0,0,0,  3'd0,5'b11100,M0,S0);
    add(0,0,BAD,NOFN,0,0,0,  3'd1,5'b00000,M0,7'b0000001);
    add(0,0,R,NOFN,0,0,0,    3'd0,5'b11100,M0,S0);
    add(0,0,R,NOFN,0,0,0,    3'd1,5'b00000,M0,7'b0000001);
    add(0,0,SW,NOFN,0,0,0,   3'd0,5'b11100,M0,S0);
    add(0,0,SW,NOFN,0,0,0,   3'd1,5'b00000,M0,S0);
    add(0,0,SW,NOFN,0,0,0,   3'd2,5'b00000,10'b00_1_00_01_000,S0);
    add(0,0,SW,NOFN,0,0,0,   3'd3,5'b10001,M0,S0);
    add(0,0,LW,NOFN,0,0,0,   3'd0,5'b11100,M0,S0);
    add(0,0,LW,NOFN,0,0,0,   3'd1,5'b00000,M0,S0);
    add(0,0,LW,NOFN,0,0,0,   3'd2,5'b00000,10'b00_1_00_01_000,S0);
    add(0,0,LW,NOFN,0,0,0,   3'd3,5'b10000,M0,S0);
    add(0,0,LW,NOFN,0,0,0,   3'd4,5'b00010,10'b00_0_01_00_000,S0);
    add(0,0,LW,NOFN,0,0,0,   3'd0,5'b11100,M0,S0);

    // MEM_LAT=3: lw then sw, then a reset partway through FETCH restarts the wait.
    add(1,1,LW,NOFN,0,0,0, 3'd0,5'b00000,M0,S0);
    add(1,0,LW,NOFN,0,0,0, 3'd0,5'b10000,M0,S0);
    add(1,0,LW,NOFN,0,0,0, 3'd0,5'b10000,M0,S0);
    add(1,0,LW,NOFN,0,0,0, 3'd0,5'b11100,M0,S0);
    add(1,0,LW,NOFN,0,0,0, 3'd1,5'b00000,M0,S0);
    add(1,0,LW,NOFN,0,0,0, 3'd2,5'b00000,10'b00_1_00_01_000,S0);
    add(1,0,LW,NOFN,0,0,0, 3'd3,5'b10000,M0,S0);
    add(1,0,LW,NOFN,0,0,0, 3'd3,5'b10000,M0,S0);
    add(1,0,LW,NOFN,0,0,0, 3'd3,5'b10000,M0,S0);
    add(1,0,LW,NOFN,0,0,0, 3'd4,5'b00010,10'b00_0_01_00_000,S0);
    add(1,0,SW,NOFN,0,0,0, 3'd0,5'b10000,M0,S0);
    add(1,0,SW,NOFN,0,0,0, 3'd0,5'b10000,M0,S0);
    add(1,0,SW,NOFN,0,0,0, 3'd0,5'b11100,M0,S0);
    add(1,0,SW,NOFN,0,0,0, 3'd1,5'b00000,M0,S0);
    add(1,0,SW,NOFN,0,0,0, 3'd2,5'b00000,10'b00_1_00_01_000,S0);
    add(1,0,SW,NOFN,0,0,0, 3'd3,5'b10000,M0,S0);
    add(1,0,SW,NOFN,0,0,0, 3'd3,5'b10000,M0,S0);
    add(1,0,SW,NOFN,0,0,0, 3'd3,5'b10001,M0,S0);
    add(1,0,SW,NOFN,0,0,0, 3'd0,5'b10000,M0,S0);
    add(1,1,SW,NOFN,0,0,0, 3'd0,5'b00000,M0,S0);
    add(1,0,SW,NOFN,0,0,0, 3'd0,5'b10000,M0,S0);
    add(1,0,SW,NOFN,0,0,0, 3'd0,5'b10000,M0,S0);
    add(1,0,SW,NOFN,0,0,0, 3'd0,5'b11100,M0,S0);

    // USE_RDY=1: sw stalls in MEM until mem_rdy; mem_rdy outside FETCH/MEM is ignored.
    add(2,1,SW,NOFN,0,0,0,  3'd0,5'b00000,M0,S0);
    add(2,0,SW,NOFN,0,0,1,  3'd0,5'b11100,M0,S0);
    add(2,0,SW,NOFN,0,0,1,  3'd1,5'b00000,M0,S0);
    add(2,0,SW,NOFN,0,0,1,  3'd2,5'b00000,10'b00_1_00_01_000,S0);
    add(2,0,SW,NOFN,0,0,0,  3'd3,5'b10000,M0,S0);
    add(2,0,SW,NOFN,0,0,0,  3'd3,5'b10000,M0,S0);
    add(2,0,SW,NOFN,0,0,0,  3'd3,5'b10000,M0,S0);
    add(2,0,SW,NOFN,0,0,0,  3'd3,5'b10000,M0,S0);
    add(2,0,SW,NOFN,0,0,1,  3'd3,5'b10001,M0,S0);
    add(2,0,BAD,NOFN,0,0,0, 3'd0,5'b10000,M0,S0);
    add(2,0,BAD,NOFN,0,0,0, 3'd0,5'b10000,M0,S0);
    add(2,0,BAD,NOFN,0,0,1, 3'd0,5'b11100,M0,S0);
    add(2,0,BAD,NOFN,0,0,1, 3'd1,5'b00000,M0,7'b0000001);
    add(2,0,BAD,NOFN,0,0,0, 3'd0,5'b10000,M0,S0);

    $display("[TB] applying %0d vectors", vec.size());
    foreach (vec[i]) begin
      @(posedge clk);
      #1 applyStimulus(vec[i], i);
      @(negedge clk);
      checkOutput();
    end

    // FETCH latency on the MEM_LAT=3 instance, measured with a bounded wait.
    @(posedge clk);
    #1 rst = 1'b1; mem_rdy = 1'b0; opcode = R; funct = ADDU;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      cyc++;
      if (obs[1][19]) seen = 1'b1;
    end
    checks++;
    if (!seen || cyc != 3) begin
      errors++;
      $display("[TB] FAIL fetch_latency_lat3 got=%0d seen=%0d exp=3", cyc, seen);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
